// File: rtl/ahb_sram_slave.sv
// AHB-Lite word slave in front of the single-request SRAM interface (start / writemode / io_done).
// Define AHB_SRAM_ERR_RESP_EN to enable transfer validity checks and the two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int W_ADDR_SIZE_BITS = 16,
    parameter int DATA_BITS        = 24,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        hsel,
    input  logic [31:0]                 haddr,
    input  logic [1:0]                  htrans,
    input  logic                        hwrite,
    input  logic [2:0]                  hsize,
    input  logic [31:0]                 hwdata,
    input  logic                        hready,
    output logic [31:0]                 hrdata,
    output logic                        hreadyout,
    output logic [1:0]                  hresp,
    output logic                        mem_start,
    output logic                        mem_writemode,
    output logic [W_ADDR_SIZE_BITS-1:0] mem_address,
    output logic [DATA_BITS-1:0]        mem_w_data,
    input  logic [DATA_BITS-1:0]        mem_r_data,
    input  logic                        mem_io_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WDATA = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR1  = 3'd5;
    localparam logic [2:0] S_ERR2  = 3'd6;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]                  r_state;
    logic [2:0]                  w_nxt;
    logic [CNT_W-1:0]            r_cnt;
    logic [31:0]                 r_hrdata;
    logic                        r_hreadyout;
    logic                        r_mem_start;
    logic                        r_mem_writemode;
    logic [W_ADDR_SIZE_BITS-1:0] r_mem_address;
    logic [DATA_BITS-1:0]        r_mem_w_data;
    logic                        w_accept;
    logic                        w_valid;
    logic [31:0]                 w_rd_word;
    logic                        w_unused;

    // DONE doubles as an idle slot so the next address phase pipelines in
    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && hsel && hready && htrans[1];

`ifdef AHB_SRAM_ERR_RESP_EN
    assign w_valid = (hsize == 3'b010) && (haddr[1:0] == 2'b00)
                   && ((haddr >> (W_ADDR_SIZE_BITS + 2)) == 32'd0);
`else
    assign w_valid = 1'b1;
`endif

    // Bits that do not reach the datapath in every configuration
    assign w_unused = ^{hwdata, haddr, hsize};

    always_comb begin
        w_rd_word                = '0;
        w_rd_word[DATA_BITS-1:0] = mem_r_data;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (!w_accept)     w_nxt = S_IDLE;
                else if (!w_valid) w_nxt = S_ERR1;
                else if (hwrite)   w_nxt = S_WDATA;
                else               w_nxt = S_REQ;
            end
            S_WDATA: w_nxt = S_REQ;
            S_REQ:   w_nxt = S_WAIT;
            S_WAIT: begin
                // io_done on the final count still completes normally
                if (mem_io_done) w_nxt = S_DONE;
                else if (r_cnt == CNT_LAST) begin
`ifdef AHB_SRAM_ERR_RESP_EN
                    w_nxt = S_ERR1;
`else
                    w_nxt = S_DONE;
`endif
                end
            end
            S_ERR1:  w_nxt = S_ERR2;
            S_ERR2:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_hrdata        <= '0;
            r_hreadyout     <= 1'b1;
            r_mem_start     <= 1'b0;
            r_mem_writemode <= 1'b0;
            r_mem_address   <= '0;
            r_mem_w_data    <= '0;
        end else begin
            r_state     <= w_nxt;
            r_hreadyout <= !((w_nxt == S_WDATA) || (w_nxt == S_REQ) ||
                             (w_nxt == S_WAIT)  || (w_nxt == S_ERR1));
            r_mem_start <= (w_nxt == S_REQ);
            r_cnt       <= ((r_state == S_WAIT) && (w_nxt == S_WAIT)) ? r_cnt + 1'b1 : '0;
            if (w_accept && w_valid) begin
                r_mem_address   <= haddr[W_ADDR_SIZE_BITS+1:2];
                r_mem_writemode <= hwrite;
            end
            if (r_state == S_WDATA)
                r_mem_w_data <= hwdata[DATA_BITS-1:0];
            if ((r_state == S_WAIT) && mem_io_done && !r_mem_writemode)
                r_hrdata <= w_rd_word;
        end
    end

`ifdef AHB_SRAM_ERR_RESP_EN
    logic [1:0] r_hresp;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_hresp <= 2'b00;
        else        r_hresp <= ((w_nxt == S_ERR1) || (w_nxt == S_ERR2)) ? 2'b01 : 2'b00;
    end

    assign hresp = r_hresp;
`else
    assign hresp = 2'b00;
`endif

    assign hrdata        = r_hrdata;
    assign hreadyout     = r_hreadyout;
    assign mem_start     = r_mem_start;
    assign mem_writemode = r_mem_writemode;
    assign mem_address   = r_mem_address;
    assign mem_w_data    = r_mem_w_data;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: AHB master driver, SRAM responder model, data-phase monitor.
module tb_ahb_sram_slave;

    localparam int AW = 16;
    localparam int DW = 24;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          hsel = 1'b0;
    logic [31:0]   haddr = '0;
    logic [1:0]    htrans = 2'b00;
    logic          hwrite = 1'b0;
    logic [2:0]    hsize = 3'b010;
    logic [31:0]   hwdata = '0;
    logic          hready;
    logic [31:0]   hrdata;
    logic          hreadyout;
    logic [1:0]    hresp;
    logic          mem_start;
    logic          mem_writemode;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_w_data;
    logic [DW-1:0] mem_r_data = '0;
    logic          mem_io_done = 1'b0;

    assign hready = hreadyout;

    always #5 clk = ~clk;

    ahb_sram_slave #(.W_ADDR_SIZE_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .n_rst(n_rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
        .mem_start(mem_start), .mem_writemode(mem_writemode), .mem_address(mem_address),
        .mem_w_data(mem_w_data), .mem_r_data(mem_r_data), .mem_io_done(mem_io_done)
    );

    typedef struct { logic wm; logic [AW-1:0] addr; logic [DW-1:0] wd; } req_t;
    typedef struct { logic [1:0] resp; int waits; logic chk_d; logic [31:0] rdata; } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          dd = 1;          // WAIT cycle on which the SRAM answers; -1 = never
    logic [31:0] last_rd = '0;
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];
    logic [DW-1:0] sram    [0:(1<<AW)-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // SRAM responder: checks each request against the scoreboard, answers after dd WAIT cycles
    initial begin : model
        logic pend, m_wm, prev;
        logic [AW-1:0] m_a;
        logic [DW-1:0] m_wd;
        int wc;
        req_t r;
        pend = 0; m_wm = 0; prev = 0; m_a = '0; m_wd = '0; wc = 0;
        for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
        sram[4] = 24'h123456;
        forever begin
            @(negedge clk); #1;
            mem_io_done = 1'b0;
            if (!n_rst) begin
                pend = 0; prev = 0; req_q.delete();
            end else begin
                if (pend) begin
                    wc++;
                    if (wc == dd) begin
                        mem_io_done = 1'b1;
                        mem_r_data  = sram[m_a];
                        if (m_wm) sram[m_a] = m_wd;
                        pend = 0;
                    end
                end
                if (mem_start) begin
                    chk("mem_start_width", 32'(prev), 32'd0);
                    if (req_q.size() == 0) chk("mem_start_unexpected", 32'd1, 32'd0);
                    else begin
                        r = req_q.pop_front();
                        chk("mem_writemode", 32'(mem_writemode), 32'(r.wm));
                        chk("mem_address", 32'(mem_address), 32'(r.addr));
                        if (r.wm) chk("mem_w_data", 32'(mem_w_data), 32'(r.wd));
                    end
                    pend = 1; wc = 0;
                    m_a = mem_address; m_wm = mem_writemode; m_wd = mem_w_data;
                end
                prev = mem_start;
            end
        end
    end

    // Data-phase monitor: counts wait states and pops the expected response on completion
    initial begin : mon
        bit act;
        int w;
        rsp_t r;
        act = 0; w = 0;
        forever begin
            @(negedge clk); #1;
            if (!n_rst) begin
                act = 0; rsp_q.delete();
            end else begin
                if (act) begin
                    if (!hreadyout) begin
                        w++;
                        if (w > 300) begin chk("data_phase_stall", 32'd0, 32'd1); act = 0; end
                    end else begin
                        act = 0;
                        if (rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                        else begin
                            r = rsp_q.pop_front();
                            chk("hresp", 32'(hresp), 32'(r.resp));
                            chk("wait_states", 32'(w), 32'(r.waits));
                            if (r.chk_d) chk("hrdata", hrdata, r.rdata);
                        end
                    end
                end
                if (hsel && hready && htrans[1]) begin act = 1; w = 0; end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the address phase is taken
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        logic          valid;
        logic [AW-1:0] idx;
        int            base;
        int            n;
        rsp_t          e;
        valid = 1'b1;
`ifdef AHB_SRAM_ERR_RESP_EN
        valid = (sz == 3'b010) && (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
`endif
        idx  = a[AW+1:2];
        base = wr ? 2 : 1;
        e = '{resp: 2'b00, waits: 0, chk_d: 1'b0, rdata: 32'h0};
        if (!valid) begin
            e.resp = 2'b01; e.waits = 1;
        end else begin
            req_q.push_back('{wm: wr, addr: idx, wd: wd[DW-1:0]});
            if (dd < 0) begin
`ifdef AHB_SRAM_ERR_RESP_EN
                e.resp = 2'b01; e.waits = base + TO + 1;
`else
                e.waits = base + TO; e.chk_d = !wr; e.rdata = last_rd;
`endif
            end else begin
                e.waits = base + dd;
                if (wr) exp_mem[idx] = wd[DW-1:0];
                else begin
                    e.rdata = {8'h00, exp_mem[idx]}; e.chk_d = 1'b1; last_rd = e.rdata;
                end
            end
        end
        rsp_q.push_back(e);
        hsel = 1'b1; haddr = a; hwrite = wr; hsize = sz; htrans = 2'b10;
        n = 0;
        while (hreadyout !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("addr_phase_timeout", 32'd0, 32'd1);
        @(negedge clk);
        hwdata = wd; htrans = 2'b00; hsel = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || req_q.size() != 0) && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) chk("drain_timeout", 32'd0, 32'd1);
        @(negedge clk); @(negedge clk);
    endtask

    task automatic chk_reset_vals();
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_mem_start", 32'(mem_start), 32'd0);
        chk("rst_mem_writemode", 32'(mem_writemode), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_w_data", 32'(mem_w_data), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) exp_mem[i] = '0;
        exp_mem[4] = 24'h123456;
        repeat (3) @(negedge clk);
        #2 chk_reset_vals();
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);

        // read with io_done on the first WAIT cycle, then write answered on WAIT 3
        dd = 1; xfer(1'b0, 32'h10, 3'b010, 32'h0);           drain();
        dd = 3; xfer(1'b1, 32'h10, 3'b010, 32'h00AB_CDEF);   drain();

        // back-to-back write/read, second address phase lands in DONE
        dd = 1; xfer(1'b1, 32'h8, 3'b010, 32'h00C0_FFEE); xfer(1'b0, 32'h8, 3'b010, 32'h0); drain();
        dd = 2; xfer(1'b1, 32'h100, 3'b010, 32'hFF55_AA33); xfer(1'b0, 32'h100, 3'b010, 32'h0);
                xfer(1'b0, 32'h10, 3'b010, 32'h0);           drain();

        // transfers that are invalid only when checking is enabled
        dd = 1; xfer(1'b1, 32'h10, 3'b000, 32'h0011_2233);   drain();
        xfer(1'b0, 32'h0004_0000, 3'b010, 32'h0);            drain();
        xfer(1'b0, 32'h12, 3'b010, 32'h0);                   drain();
        xfer(1'b0, 32'h10, 3'b010, 32'h0);                   drain();

        // io_done on the last allowed WAIT cycle, then no io_done at all
        dd = TO; xfer(1'b0, 32'h8, 3'b010, 32'h0);           drain();
        dd = -1; xfer(1'b0, 32'h100, 3'b010, 32'h0);         drain();

        // asynchronous reset while waiting on the SRAM
        dd = -1; xfer(1'b0, 32'h8, 3'b010, 32'h0);
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b0;
        #1 chk_reset_vals();
        @(negedge clk); @(negedge clk);
        n_rst = 1'b1; last_rd = '0;
        @(negedge clk);
        dd = 2; xfer(1'b0, 32'h10, 3'b010, 32'h0);           drain();

        // selected but IDLE/BUSY: zero-wait OKAY, no SRAM request
        for (int k = 0; k < 4; k++) begin
            hsel = 1'b1; haddr = 32'h10; hwrite = 1'b1; htrans = k[0] ? 2'b01 : 2'b00;
            @(negedge clk); #1;
            chk("idle_hreadyout", 32'(hreadyout), 32'd1);
            chk("idle_hresp", 32'(hresp), 32'd0);
        end
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        drain();
        chk("rsp_q_left", 32'(rsp_q.size()), 32'd0);
        chk("req_q_left", 32'(req_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB slave (responder) that bridges bus transfers from the ARM-side master onto the single-request SRAM interface handshake (start / writemode / io_done). It decodes single word read/write transfers, inserts wait states while the SRAM access is pending, and returns read data and an OKAY or ERROR response. It sits between the AHB fabric and the SRAM interface block, in front of the off-chip 24-bit pixel SRAM.

## Interface
- W_ADDR_SIZE_BITS, 16, SRAM word-address width
- DATA_BITS, 24, SRAM word width; must be ≤ 32
- TIMEOUT_CYCLES, 64, maximum wait for mem_io_done before abandoning; must be ≥ 2

- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- haddr  in  32  byte address
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hwrite  in  1  1 = write
- hsize  in  3  transfer size; only 3'b010 (word) is supported
- hwdata  in  32  write data, valid in the data phase
- hready  in  1  bus-wide ready; an address phase is taken only when it is 1
- hrdata  out  32  {zero-pad, read word}
- hreadyout  out  1  slave ready
- hresp  out  2  00 OKAY, 01 ERROR
- mem_start  out  1  one-cycle request pulse to the SRAM interface
- mem_writemode  out  1  1 = write request
- mem_address  out  W_ADDR_SIZE_BITS  word address, haddr[W_ADDR_SIZE_BITS+1:2]
- mem_w_data  out  DATA_BITS  hwdata[DATA_BITS-1:0]
- mem_r_data  in  DATA_BITS  read word, valid while mem_io_done=1
- mem_io_done  in  1  access complete

## Operation
- FSM states: IDLE, WDATA, REQ, WAIT, DONE, ERR1, ERR2.
- Accept condition (in IDLE or DONE): hsel & hready & htrans[1]. Latch haddr, hwrite, hsize.
- Valid transfer: hsize==3'b010, haddr[1:0]==0, haddr[31:W_ADDR_SIZE_BITS+2]==0.
- Accept + invalid → ERR1 (only when the error macro is defined; see Configuration).
- Accept + valid write → WDATA. Latch hwdata[DATA_BITS-1:0] into mem_w_data, then → REQ.
- Accept + valid read → REQ.
- hsel & hready with htrans IDLE or BUSY: zero-wait OKAY, no SRAM access, state stays IDLE.
- REQ: mem_start=1 for exactly one cycle, with mem_writemode and mem_address stable → WAIT.
- WAIT: mem_address, mem_writemode, and mem_w_data are held. On mem_io_done=1 → DONE; on a read, capture mem_r_data into hrdata with the upper bits zero.
- A timeout counter clears on entry to WAIT and increments every WAIT cycle. When it reaches TIMEOUT_CYCLES-1 without mem_io_done → ERR1.
- DONE: hreadyout=1, hresp=OKAY. This cycle behaves as IDLE for the next address phase, so back-to-back transfers pipeline. With no accept → IDLE.
- ERR1: hreadyout=0, hresp=01 → ERR2.
- ERR2: hreadyout=1, hresp=01 → IDLE. No address phase is accepted in ERR2, per AHB two-cycle ERROR.
- hrdata holds its last read value until the next read completes.
- hreadyout=0 in WDATA, REQ, WAIT, and ERR1; 1 in all other states.
- Reset mid-operation: return to IDLE. A pending SRAM request is abandoned and mem_start drops immediately.

## Timing
- Reset values: hrdata=0, hreadyout=1, hresp=00, mem_start=0, mem_writemode=0, mem_address=0, mem_w_data=0, FSM=IDLE, timeout counter=0.
- All outputs are registered.
- Read: address phase at cycle A; REQ at A+1; WAIT from A+2; DONE one cycle after mem_io_done. Minimum is 2 wait states, with the data phase completing at A+3.
- Write: WDATA at A+1; REQ at A+2; WAIT from A+3. Minimum is 3 wait states, completing at A+4.
- mem_io_done is ignored outside WAIT.
- A mem_io_done that arrives on the same cycle as the timeout wins: the transfer completes OKAY.

## Configuration
- AHB_SRAM_ERR_RESP_EN defined:
  - Invalid transfers and timeouts produce the two-cycle ERROR response.
  - Invalid transfers do not access the SRAM.
- AHB_SRAM_ERR_RESP_EN undefined:
  - No validity checks: haddr[1:0], the high address bits, and hsize are ignored, and every NONSEQ/SEQ goes to WDATA or REQ.
  - Timeout → DONE with OKAY and hrdata unchanged.
  - hresp is constant 00.

## Test plan
- Write haddr=0x0000_0010, hwdata=0x00AB_CDEF, io_done after 3 WAIT cycles → one mem_start pulse with mem_address=4, mem_writemode=1, mem_w_data=0xABCDEF; hreadyout low for 5 cycles; OKAY.
- Read haddr=0x10 with mem_r_data=0x123456 at io_done → hrdata=0x0012_3456 in DONE; 2 wait states minimum when io_done comes on the first WAIT cycle.
- Back-to-back NONSEQ write then read to address 8, second address phase in DONE → no idle cycle between transfers; read returns the written word from the SRAM model.
- With the macro defined, hsize=3'b000 or haddr=0x0004_0000 → ERR1 then ERR2 (hresp=01, hreadyout 0 then 1); no mem_start.
- mem_io_done held low → ERROR after TIMEOUT_CYCLES WAIT cycles (64); the bench also runs with the macro undefined, requiring OKAY and unchanged hrdata.
- Assert n_rst low during WAIT → all outputs return to reset values asynchronously; the next transfer after release completes normally.
